// File: rtl/seq_det_pkg.sv
// seq_det_pkg: pattern-length limits and elaboration-time KMP helpers for seq_detector
package seq_det_pkg;
  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;
  function automatic int kmp_next(logic [15:0] pattern, int pat_w, int p, logic b);
    int r;
    logic ok;
    logic sb;
    r = 0;
    for (int k = 1; k < pat_w && k <= p + 1; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        sb = (p + 1 - k + i == p) ? b : pattern[4'(pat_w - 1 - (p + 1 - k + i))];
        if (sb != pattern[4'(pat_w - 1 - i)]) ok = 1'b0;
      end
      if (ok) r = k;
    end
    return r;
  endfunction
  function automatic int kmp_fail(logic [15:0] pattern, int pat_w);
    return kmp_next(pattern, pat_w, pat_w - 1, pattern[0]);
  endfunction
endpackage

// File: rtl/seq_detector_if.sv
// seq_detector_if: serial bit stream in (in_valid, in_bit, clr), status out (y, z, match_q, match_cnt)
interface seq_detector_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic in_valid;
  logic in_bit;
  logic clr;
  logic [$clog2(PAT_W)-1:0] y;
  logic z;
  logic match_q;
  logic [CNT_W-1:0] match_cnt;
  modport master(output in_valid, in_bit, clr, input y, z, match_q, match_cnt);
  modport slave(input in_valid, in_bit, clr, output y, z, match_q, match_cnt);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter with sync active-low reset, sync clear and saturation at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) q <= (!rst_n || clr) ? '0 : (inc && !(&q)) ? q + 1'b1 : q;
endmodule

// File: rtl/seq_detector.sv
// seq_detector: KMP serial pattern detector; clk, rst_n, bus = in_valid/in_bit/clr in, y/z/match_q/match_cnt out
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int             OVERLAP = 1,
  parameter int             CNT_W   = 8
) (
  input logic           clk,
  input logic           rst_n,
  seq_detector_if.slave bus
);
  localparam int PW = $clog2(PAT_W);
  logic [PW-1:0] p, p_nxt;
  logic [PW-1:0] tbl [PAT_W][2];
  logic z, m_q;
  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_chk
    $fatal(1, "seq_detector: PAT_W %0d outside 2..16", PAT_W);
  end
  for (genvar s = 0; s < PAT_W; s++) begin : g_s
    for (genvar b = 0; b < 2; b++) begin : g_b
      localparam bit FIN = (s == PAT_W - 1) && (b == int'(PATTERN[0]));
      localparam int NXT = FIN ? (OVERLAP != 0 ? kmp_fail(16'(PATTERN), PAT_W) : 0)
                               : kmp_next(16'(PATTERN), PAT_W, s, 1'(b));
      assign tbl[s][b] = PW'(NXT);
    end
  end
  assign z = rst_n & bus.in_valid & ~bus.clr & (p == PW'(PAT_W - 1)) & (bus.in_bit == PATTERN[0]);
  always_comb p_nxt = bus.clr ? '0 : bus.in_valid ? tbl[p][bus.in_bit] : p;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p   <= '0;
      m_q <= 1'b0;
    end else begin
      p   <= p_nxt;
      m_q <= z;
    end
  end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (bus.clr),
    .inc  (z),
    .q    (bus.match_cnt)
  );
  assign bus.y       = p;
  assign bus.z       = z;
  assign bus.match_q = m_q;
endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised serial pattern detector that generalises our fixed four-state sequence ASM. It matches an arbitrary `PAT_W`-bit pattern on a qualified serial bit stream, with selectable overlapping or non-overlapping detection. It provides a combinational (Mealy) match strobe, a registered match flag, the current match-progress state and a saturating match counter. It sits directly behind a serial input front-end and feeds control/status logic.

## Interface
- `PAT_W`, default 4: pattern length in bits; legal range 2..16.
- `PATTERN`, default `4'b1011`: pattern to detect, `[PAT_W-1:0]`; the MSB is the first bit received.
- `OVERLAP`, default 1: 1 = overlapping detection, 0 = restart from empty after each match.
- `CNT_W`, default 8: width of the match counter.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: qualifies `in_bit`; state advances only when it is 1.
- `in_bit` in 1: serial data bit.
- `clr` in 1: synchronous soft clear of progress and counter.
- `y` out `$clog2(PAT_W)`: current progress, i.e. number of pattern bits matched so far (0..PAT_W-1).
- `z` out 1: Mealy match strobe, combinational in the cycle the final pattern bit is accepted.
- `match_q` out 1: `z` registered; high for exactly one cycle after each `z`.
- `match_cnt` out `CNT_W`: number of matches since reset or `clr`; saturates at all-ones.

## Operation
- State is the progress register `p` (0..PAT_W-1). The expected bit is `PATTERN[PAT_W-1-p]`.
- When `in_valid=1` and the bit matches and `p<PAT_W-1`: `p <= p+1`.
- When `in_valid=1` and the bit matches and `p==PAT_W-1`: this is a match.
  - `z=1` in the same cycle.
  - `p <= OVERLAP ? F : 0`, where F is the longest proper prefix of PATTERN that is also a suffix of PATTERN.
- When `in_valid=1` and the bit mismatches: `p <=` length of the longest pattern prefix that is a suffix of (the `p` matched bits followed by `in_bit`). This is a KMP transition, never blindly 0.
- When `in_valid=0`: `p`, `match_cnt` and `match_q` hold; `z=0`. `match_q` still drops after its one cycle.
- `z = in_valid & ~clr & (p==PAT_W-1) & (in_bit==PATTERN[0])`.
- `match_cnt` increments on each cycle with `z=1` unless it is already all-ones.
- `clr=1` forces `p<=0` and `match_cnt<=0` on the next edge and suppresses `z`. `clr` beats a simultaneous match, and that match is neither counted nor flagged.
- Priority: `rst_n` > `clr` > `in_valid`.

## Timing
- Reset values with `rst_n=0` at an edge: `p=0` (so `y=0`), `match_q=0`, `match_cnt=0`. `z=0` while `rst_n=0`.
- Reset asserted mid-pattern discards progress. The first bit after release is compared against `PATTERN[PAT_W-1]`.
- Latency: `z` in cycle 0 (the accepting cycle); `match_q` and the new `match_cnt` value are visible in cycle 1.
- Back-to-back matches (overlap, e.g. pattern `11`) produce `z` on consecutive valid cycles, and `match_cnt` increments every cycle.
- One bit is accepted per clock at most; there is no backpressure.

## Structure
- Package `seq_det_pkg` holds:
  - the elaboration-time function `kmp_next(pattern, pat_w, p, bit)` that returns the next progress value;
  - the function `kmp_fail(pattern, pat_w)`.
- The RTL builds a constant transition table `[PAT_W][2]` from these functions. No runtime pattern logic.
- Sub-module `sat_counter` (params `W`; ports `clk`, `rst_n`, `clr`, `inc`, `q`) implements `match_cnt`.
- Include an elaboration check: fatal error if `PAT_W` is outside 2..16.

## Test plan
- Reset: hold `rst_n=0` for 2 cycles with random `in_bit`/`in_valid`, then check `y=0`, `z=0`, `match_q=0`, `match_cnt=0`. Assert reset after 3 pattern bits and check `y=0` on the next cycle.
- Basic (PATTERN 1011): stream 1,0,1,1, one per cycle → `y`=1,2,3 before the bits; `z=1` on the 4th bit; `match_q=1` and `match_cnt=1` on the following cycle.
- Overlap: stream 1,0,1,1,0,1,1.
  - OVERLAP=1 → `z` on bits 4 and 7, `match_cnt=2`, `y=1` after each match.
  - OVERLAP=0 → one `z` only, `match_cnt=1`.
- Mismatch fallback: stream 1,1,0,1,1 → `y` after each bit is 1,1,2,3 and then `z=1` on bit 5. Confirms the KMP transition does not reset to 0.
- Gaps and clear:
  - Interleave `in_valid=0` cycles inside 1,0,1,1 → `y` holds during gaps; `z` only on the final valid bit.
  - Assert `clr` in the cycle the 4th bit completes → `z=0`, then `y=0` and `match_cnt=0`.
- Saturation: with `CNT_W=2`, feed 5 non-overlapping matches → `match_cnt` goes 1,2,3,3,3 while `z`/`match_q` still pulse each time.
